// File: rtl/idc_pipe_if.sv
// Handshake bundle between the prefetch unit, the decoder and the execution sequencer.
// The decoder takes the slave view; the surrounding logic (or bench) takes the master view.
interface idc_pipe_if;
    logic        in_valid;
    logic [15:0] in_word;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_opc;
    logic [15:0] out_ext1;
    logic [15:0] out_ext2;
    logic [1:0]  out_nwords;
    logic [2:0]  out_class;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_opc, out_ext1, out_ext2, out_nwords, out_class
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_opc, out_ext1, out_ext2, out_nwords, out_class
    );
endinterface

// File: rtl/idc_pipe.sv
// Pipelined VM1 instruction decoder: prefetch FIFO, opcode/extension assembly FSM and
// a registered, classified instruction record handed over with valid/ready.
module idc_pipe #(
    parameter int DEPTH      = 4,
    parameter bit EIS        = 1'b0,
    parameter bit VM1_STRICT = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    idc_pipe_if.slave               bus,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        C_NOF = 3'd0, C_BRA = 3'd1, C_CCO = 3'd2, C_SGL = 3'd3,
        C_DBL = 3'd4, C_RSD = 3'd5, C_UNU = 3'd6
    } iclass_t;

    typedef enum logic [1:0] {S_OPC, S_EXT1, S_EXT2, S_OUT} state_t;

    // Operand field needs an extension word for index modes and for PC immediate/absolute.
    function automatic logic need_ext(input logic [5:0] f);
        return (f[5:3] >= 3'd6) || ((f[2:0] == 3'd7) && (f[5:3] inside {3'd2, 3'd3}));
    endfunction

    function automatic iclass_t classify(input logic [15:0] op);
        logic [2:0] d4, d3, d2, d1, d0;
        iclass_t    mfp_cls, eis_cls, cls;
        d4      = op[14:12];
        d3      = op[11:9];
        d2      = op[8:6];
        d1      = op[5:3];
        d0      = op[2:0];
        mfp_cls = VM1_STRICT ? C_UNU : C_SGL;
        eis_cls = EIS ? C_RSD : C_UNU;
        cls     = C_UNU;
        if (d4 inside {[3'd1:3'd6]}) begin
            cls = C_DBL;
        end else if (d4 == 3'd0) begin
            case (d3)
                3'd0: begin
                    if (op[15]) begin
                        cls = C_BRA;
                    end else begin
                        case (d2)
                            3'd0:       cls = (d1 == 3'd0 && d0 != 3'd7) ? C_NOF : C_UNU;
                            3'd1, 3'd3: cls = C_SGL;
                            3'd2: begin
                                case (d1)
                                    3'd0:             cls = C_SGL;
                                    3'd3:             cls = C_NOF;
                                    3'd4:             cls = (d0 == 3'd0) ? C_NOF : C_CCO;
                                    3'd5, 3'd6, 3'd7: cls = C_CCO;
                                    default:          cls = C_UNU;
                                endcase
                            end
                            default:    cls = C_BRA;
                        endcase
                    end
                end
                3'd1, 3'd2, 3'd3: cls = C_BRA;
                3'd4:             cls = op[15] ? C_NOF : C_RSD;
                3'd5:             cls = C_SGL;
                3'd6: begin
                    if (d2 inside {3'd5, 3'd6})
                        cls = mfp_cls;
                    else
                        cls = (d2 == 3'd4 && !op[15]) ? C_NOF : C_SGL;
                end
                default:          cls = C_UNU;
            endcase
        end else if (!op[15]) begin
            case (d3)
                3'd0, 3'd1, 3'd2, 3'd3: cls = eis_cls;
                3'd4:                   cls = C_RSD;
                3'd7:                   cls = C_BRA;
                default:                cls = C_UNU;
            endcase
        end
        return cls;
    endfunction

    function automatic logic [1:0] ext_count(input logic [15:0] op, input iclass_t cls);
        case (cls)
            C_DBL:        return {1'b0, need_ext(op[11:6])} + {1'b0, need_ext(op[5:0])};
            C_SGL, C_RSD: return {1'b0, need_ext(op[5:0])};
            default:      return 2'd0;
        endcase
    endfunction

    // Prefetch FIFO
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic [15:0]   head;

    assign full         = (count == FULL_LVL);
    assign empty        = (count == '0);
    assign bus.in_ready = !full && !flush;
    assign push         = bus.in_valid && bus.in_ready;
    assign head         = mem[rd_ptr];
    assign level        = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_word;
    end

    // Assembly FSM and output record
    state_t      state;
    logic        out_valid_q;
    logic [15:0] opc_q, ext1_q, ext2_q;
    logic [1:0]  nwords_q;
    iclass_t     class_q;
    iclass_t     head_cls;
    logic [1:0]  head_nw;
    logic        opc_phase;

    assign head_cls  = classify(head);
    assign head_nw   = ext_count(head, head_cls);
    // The output register is free in S_OPC, or in S_OUT on the cycle it is handed over.
    assign opc_phase = (state == S_OPC) || (state == S_OUT && bus.out_ready);
    assign pop       = !empty && !flush && (opc_phase || state == S_EXT1 || state == S_EXT2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_OPC;
            out_valid_q <= 1'b0;
            opc_q       <= '0;
            ext1_q      <= '0;
            ext2_q      <= '0;
            nwords_q    <= '0;
            class_q     <= C_NOF;
        end else if (flush) begin
            state       <= S_OPC;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_OPC, S_OUT: begin
                    if (opc_phase) begin
                        if (!empty) begin
                            opc_q       <= head;
                            class_q     <= head_cls;
                            nwords_q    <= head_nw;
                            state       <= (head_nw == 2'd0) ? S_OUT : S_EXT1;
                            out_valid_q <= (head_nw == 2'd0);
                        end else begin
                            state       <= S_OPC;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                S_EXT1: begin
                    if (!empty) begin
                        ext1_q <= head;
                        if (nwords_q == 2'd2) begin
                            state <= S_EXT2;
                        end else begin
                            state       <= S_OUT;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_EXT2: begin
                    if (!empty) begin
                        ext2_q      <= head;
                        state       <= S_OUT;
                        out_valid_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_opc    = opc_q;
    assign bus.out_ext1   = ext1_q;
    assign bus.out_ext2   = ext2_q;
    assign bus.out_nwords = nwords_q;
    assign bus.out_class  = class_q;
endmodule

// File: tb/tb_idc_pipe.sv
// Directed bench for idc_pipe: default build plus an EIS=1 / VM1_STRICT=0 build fed in parallel.
module tb_idc_pipe;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       en2 = 1'b0;
    logic [2:0] level, level2;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         vcount = 0;
    int         first_push_cyc = 0;

    typedef struct {
        logic [15:0] opc;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [1:0]  nw;
        logic [2:0]  cls;
        int          cyc;
    } rec_t;

    rec_t        q[$];
    rec_t        q2[$];
    logic [15:0] stim[$];

    idc_pipe_if bus();
    idc_pipe_if bus2();

    assign bus2.in_valid  = bus.in_valid & en2;
    assign bus2.in_word   = bus.in_word;
    assign bus2.out_ready = 1'b1;

    idc_pipe #(.DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus), .level(level)
    );

    idc_pipe #(.DEPTH(4), .EIS(1'b1), .VM1_STRICT(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus2), .level(level2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Handshakes are recorded at the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (bus.out_valid) vcount++;
        if (reset_n && !flush && bus.out_valid && bus.out_ready)
            q.push_back('{bus.out_opc, bus.out_ext1, bus.out_ext2, bus.out_nwords, bus.out_class, cyc});
        if (reset_n && !flush && en2 && bus2.out_valid)
            q2.push_back('{bus2.out_opc, bus2.out_ext1, bus2.out_ext2, bus2.out_nwords, bus2.out_class, cyc});
    end

    task automatic send_stim();
        int guard;
        foreach (stim[i]) begin
            bus.in_valid = 1'b1;
            bus.in_word  = stim[i];
            guard = 0;
            @(negedge clk);
            while (!bus.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                total++; bad++;
                $display("FAIL push_timeout word=%06o never accepted", stim[i]);
            end
            if (i == 0) first_push_cyc = cyc;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic get_rec(input bit alt, input string tag, output rec_t r);
        int n = 0;
        r = '{16'h0, 16'h0, 16'h0, 2'd0, 3'd0, 0};
        while ((alt ? q2.size() : q.size()) == 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if ((alt ? q2.size() : q.size()) == 0) begin
            total++; bad++;
            $display("FAIL %s no record within 40 cycles", tag);
        end else begin
            r = alt ? q2.pop_front() : q.pop_front();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_opc !== 16'h0)    begin bad++; $display("FAIL rst_opc got=%06o want=0", bus.out_opc); end
        total++; if (bus.out_ext1 !== 16'h0 || bus.out_ext2 !== 16'h0)
                 begin bad++; $display("FAIL rst_ext got=%06o/%06o want=0/0", bus.out_ext1, bus.out_ext2); end
        total++; if (bus.out_nwords !== 2'd0 || bus.out_class !== 3'd0)
                 begin bad++; $display("FAIL rst_rec nw=%0d cls=%0d want=0/0", bus.out_nwords, bus.out_class); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (level !== 3'd0)           begin bad++; $display("FAIL rst_level got=%0d want=0", level); end
        total++; if (bus.in_ready !== 1'b1)    begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_mov_abs();
        rec_t r;
        bus.out_ready = 1'b1;
        q.delete();
        stim = '{16'o012737, 16'o001234, 16'o177560};
        vcount = 0;
        send_stim();
        get_rec(1'b0, "mov", r);
        total++; if (r.opc !== 16'o012737) begin bad++; $display("FAIL mov_opc got=%06o want=012737", r.opc); end
        total++; if (r.cls !== 3'd4)       begin bad++; $display("FAIL mov_class got=%0d want=4", r.cls); end
        total++; if (r.nw !== 2'd2)        begin bad++; $display("FAIL mov_nwords got=%0d want=2", r.nw); end
        total++; if (r.e1 !== 16'o001234)  begin bad++; $display("FAIL mov_ext1 got=%06o want=001234", r.e1); end
        total++; if (r.e2 !== 16'o177560)  begin bad++; $display("FAIL mov_ext2 got=%06o want=177560", r.e2); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (vcount !== 1)         begin bad++; $display("FAIL mov_valid_cycles got=%0d want=1", vcount); end
    endtask

    task automatic test_back_to_back();
        rec_t        r;
        logic [15:0] w  [3];
        logic [2:0]  cl [3];
        w  = '{16'o000401, 16'o005000, 16'o000241};
        cl = '{3'd1, 3'd3, 3'd2};
        bus.out_ready = 1'b1;
        q.delete();
        stim = '{w[0], w[1], w[2]};
        send_stim();
        for (int i = 0; i < 3; i++) begin
            get_rec(1'b0, "b2b", r);
            total++; if (r.opc !== w[i] || r.cls !== cl[i] || r.nw !== 2'd0)
                     begin bad++; $display("FAIL b2b_rec%0d got=%06o/%0d/%0d want=%06o/%0d/0", i, r.opc, r.cls, r.nw, w[i], cl[i]); end
            total++; if (r.cyc !== first_push_cyc + 2 + i)
                     begin bad++; $display("FAIL b2b_cycle%0d got=%0d want=%0d", i, r.cyc, first_push_cyc + 2 + i); end
        end
    endtask

    task automatic test_full();
        rec_t        r;
        logic [15:0] w [6];
        int          idx = 0;
        w = '{16'o000241, 16'o000242, 16'o000244, 16'o000250, 16'o000257, 16'o000261};
        bus.out_ready = 1'b0;
        q.delete();
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = 1'b1;
            bus.in_word  = w[idx];
            @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk); #1;
        end
        bus.in_word = w[idx];
        total++; if (idx !== 5)            begin bad++; $display("FAIL full_accepted got=%0d want=5", idx); end
        total++; if (level !== 3'd4)       begin bad++; $display("FAIL full_level got=%0d want=4", level); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_no_push got=%b want=0", bus.in_ready); end
        for (int c = 0; c < 10 && idx < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 6) bus.in_word = w[idx];
        end
        bus.in_valid = 1'b0;
        total++; if (idx !== 6)            begin bad++; $display("FAIL full_drain_accept got=%0d want=6", idx); end
        for (int i = 0; i < 6; i++) begin
            get_rec(1'b0, "full_order", r);
            total++; if (r.opc !== w[i])   begin bad++; $display("FAIL full_order%0d got=%06o want=%06o", i, r.opc, w[i]); end
        end
    endtask

    task automatic test_underflow_ext();
        rec_t r;
        bus.out_ready = 1'b1;
        q.delete();
        stim = '{16'o004737};
        send_stim();
        repeat (4) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_valid got=%b want=0", bus.out_valid); end
        stim = '{16'o001000, 16'o016767, 16'o000010, 16'o000020, 16'o105037, 16'o000177};
        send_stim();
        get_rec(1'b0, "jsr", r);
        total++; if (r.opc !== 16'o004737 || r.cls !== 3'd5 || r.nw !== 2'd1 || r.e1 !== 16'o001000)
                 begin bad++; $display("FAIL jsr_rec got=%06o/%0d/%0d/%06o want=004737/5/1/001000", r.opc, r.cls, r.nw, r.e1); end
        get_rec(1'b0, "mov_idx", r);
        total++; if (r.cls !== 3'd4 || r.nw !== 2'd2 || r.e1 !== 16'o000010 || r.e2 !== 16'o000020)
                 begin bad++; $display("FAIL mov_idx_rec got=%0d/%0d/%06o/%06o want=4/2/000010/000020", r.cls, r.nw, r.e1, r.e2); end
        get_rec(1'b0, "clrb_abs", r);
        total++; if (r.cls !== 3'd3 || r.nw !== 2'd1 || r.e1 !== 16'o000177 || r.e2 !== 16'o000020)
                 begin bad++; $display("FAIL clrb_rec got=%0d/%0d/%06o/%06o want=3/1/000177/000020", r.cls, r.nw, r.e1, r.e2); end
    endtask

    task automatic test_flush();
        rec_t r;
        bus.out_ready = 1'b1;
        q.delete();
        stim = '{16'o016700};
        send_stim();
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_word  = 16'o000777;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", bus.in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (level !== 3'd0 || bus.out_valid !== 1'b0)
                 begin bad++; $display("FAIL flush_state level=%0d valid=%b want=0/0", level, bus.out_valid); end
        stim = '{16'o000240};
        send_stim();
        get_rec(1'b0, "flush_next", r);
        total++; if (r.opc !== 16'o000240 || r.cls !== 3'd0 || r.nw !== 2'd0)
                 begin bad++; $display("FAIL flush_next got=%06o/%0d/%0d want=000240/0/0", r.opc, r.cls, r.nw); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (q.size() !== 0)       begin bad++; $display("FAIL flush_extra_records got=%0d want=0", q.size()); end
    endtask

    task automatic test_options();
        rec_t r;
        bus.out_ready = 1'b1;
        q.delete();
        q2.delete();
        en2 = 1'b1;
        stim = '{16'o070102, 16'o006512};
        send_stim();
        get_rec(1'b0, "eis0", r);
        total++; if (r.cls !== 3'd6 || r.nw !== 2'd0) begin bad++; $display("FAIL eis0_class got=%0d/%0d want=6/0", r.cls, r.nw); end
        get_rec(1'b0, "strict1", r);
        total++; if (r.cls !== 3'd6)       begin bad++; $display("FAIL strict1_class got=%0d want=6", r.cls); end
        get_rec(1'b1, "eis1", r);
        total++; if (r.cls !== 3'd5 || r.nw !== 2'd0) begin bad++; $display("FAIL eis1_class got=%0d/%0d want=5/0", r.cls, r.nw); end
        get_rec(1'b1, "strict0", r);
        total++; if (r.cls !== 3'd3 || r.nw !== 2'd0) begin bad++; $display("FAIL strict0_class got=%0d/%0d want=3/0", r.cls, r.nw); end
        en2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        rec_t r;
        bus.out_ready = 1'b1;
        q.delete();
        stim = '{16'o016700};
        send_stim();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.out_opc !== 16'o016700 || bus.out_class !== 3'd4)
                 begin bad++; $display("FAIL pre_reset got=%06o/%0d want=016700/4", bus.out_opc, bus.out_class); end
        reset_n = 1'b0;
        #1;
        total++; if (bus.out_opc !== 16'h0 || bus.out_class !== 3'd0 || bus.out_nwords !== 2'd0 || bus.out_valid !== 1'b0)
                 begin bad++; $display("FAIL mid_reset_out got=%06o/%0d/%0d/%b want=0/0/0/0", bus.out_opc, bus.out_class, bus.out_nwords, bus.out_valid); end
        total++; if (level !== 3'd0)       begin bad++; $display("FAIL mid_reset_level got=%0d want=0", level); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        q.delete();
        stim = '{16'o000000};
        send_stim();
        get_rec(1'b0, "post_reset", r);
        total++; if (r.opc !== 16'o000000 || r.cls !== 3'd0 || r.nw !== 2'd0)
                 begin bad++; $display("FAIL post_reset got=%06o/%0d/%0d want=0/0/0", r.opc, r.cls, r.nw); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_word   = 16'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_mov_abs();
        test_back_to_back();
        test_full();
        test_underflow_ext();
        test_flush();
        test_options();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
